lsu_ctrl: RTL and testbench

- Load/store unit that sits directly upstream of data_mem and is the only master driving it.
- Takes one decoded RV32I load/store per handshake from the execute stage.
- Checks alignment and performs sub-word stores as a read-modify-write, since data_mem only writes whole words.
- Extracts and sign/zero-extends load data, then returns a registered response to the pipeline.

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_align.sv | 62 ++++++
 rtl/lsu_ctrl.sv | 171 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: types, constants and helpers shared by the load/store unit.
//   lsu_state_t     : controller FSM states (IDLE, RMW_WR, RESP)
//   LSU_F3_*        : RV32I load/store funct3 width/sign codes
//   is_misaligned() : alignment check for a funct3 width and byte offset
//   is_legal_load() / is_legal_store() : funct3 legality per access class
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RMW_WR = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    localparam logic [2:0] LSU_F3_B  = 3'b000;
    localparam logic [2:0] LSU_F3_H  = 3'b001;
    localparam logic [2:0] LSU_F3_W  = 3'b010;
    localparam logic [2:0] LSU_F3_BU = 3'b100;
    localparam logic [2:0] LSU_F3_HU = 3'b101;

    // Width is carried in funct3[1:0]; the sign bit does not matter here.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (funct3[1:0])
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic is_legal_load(input logic [2:0] funct3);
        return (funct3 inside {LSU_F3_B, LSU_F3_H, LSU_F3_W, LSU_F3_BU, LSU_F3_HU});
    endfunction

    function automatic logic is_legal_store(input logic [2:0] funct3);
        return (funct3 inside {LSU_F3_B, LSU_F3_H, LSU_F3_W});
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational byte-lane steering for the LSU.
//   funct3      : access width/sign code
//   addr_lo     : byte offset within the word
//   rd_word     : word read from data memory
//   load_data   : selected byte/half/word, sign- or zero-extended
//   old_word    : current memory word for a sub-word store
//   wr_data     : store data, low bytes significant
//   merged_word : old_word with the store bytes replaced
// Lane logic assumes a 4-byte RV32 word.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rd_word,
    output logic [XLEN-1:0] load_data,
    input  logic [XLEN-1:0] old_word,
    input  logic [XLEN-1:0] wr_data,
    output logic [XLEN-1:0] merged_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Halfwords sit on lanes {1,0} or {3,2}, picked by addr_lo[1].
    assign byte_v = rd_word[{addr_lo, 3'b000} +: 8];
    assign half_v = rd_word[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        load_data = rd_word;
        case (funct3)
            LSU_F3_B:  load_data = {{(XLEN-8){byte_v[7]}}, byte_v};
            LSU_F3_H:  load_data = {{(XLEN-16){half_v[15]}}, half_v};
            LSU_F3_BU: load_data = {{(XLEN-8){1'b0}}, byte_v};
            LSU_F3_HU: load_data = {{(XLEN-16){1'b0}}, half_v};
            default:   load_data = rd_word;
        endcase
    end

    // Each byte lane independently chooses between the old byte and the
    // appropriate byte of the store data.
    genvar gi;
    generate
        for (gi = 0; gi < XLEN / 8; gi++) begin : g_lane
            localparam logic [1:0] LANE     = 2'(gi);
            localparam int         HALF_OFS = (gi % 2) * 8;
            logic hit_b;
            logic hit_h;
            logic hit_w;
            assign hit_b = (funct3 == LSU_F3_B) && (addr_lo == LANE);
            assign hit_h = (funct3 == LSU_F3_H) && (addr_lo[1] == LANE[1]);
            assign hit_w = (funct3 == LSU_F3_W);
            assign merged_word[8*gi +: 8] = hit_b ? wr_data[7:0] :
                                            hit_h ? wr_data[HALF_OFS +: 8] :
                                            hit_w ? wr_data[8*gi +: 8] :
                                                    old_word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store unit, sole master of data_mem.
//   req_*  : one decoded load/store per valid/ready handshake (ready only in IDLE)
//   resp_* : one-cycle response pulse with extended load data and fault flag
//   mem_*  : word-addressed data_mem port; mem_rd_data is combinational
// Sub-word stores are a read-modify-write: read and merge in the accept
// cycle, write the registered merged word in RMW_WR.
// Optional macro LSU_PERF_CNT_EN adds perf_loads/perf_stores/perf_faults.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int              XLEN          = 32,
    parameter logic [XLEN-1:0] RESET_RD_DATA = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_load,
    input  logic            req_is_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wr_data,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rd_data,
    output logic            resp_fault,
    output logic            mem_wr_sel,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wr_data,
    input  logic [XLEN-1:0] mem_rd_data
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]     perf_loads,
    output logic [31:0]     perf_stores,
    output logic [31:0]     perf_faults
`endif
);

    lsu_state_t      state_q, state_d;
    logic [XLEN-1:0] resp_rd_data_q, resp_rd_data_d;
    logic            resp_fault_q, resp_fault_d;
    logic [XLEN-1:0] rmw_addr_q, rmw_addr_d;
    logic [XLEN-1:0] rmw_data_q, rmw_data_d;

    logic            acc_access;
    logic            req_fault;
    logic            sw_write;
    logic [XLEN-1:0] addr_aligned;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] merged_word;

    assign req_ready    = (state_q == IDLE);
    assign addr_aligned = {req_addr[XLEN-1:2], 2'b00};
    // A valid beat carrying neither load nor store is simply not taken.
    assign acc_access   = req_valid && req_ready && (req_is_load || req_is_store);

    assign req_fault = (req_is_load && req_is_store)
                    || (req_is_load  && !is_legal_load(req_funct3))
                    || (req_is_store && !is_legal_store(req_funct3))
                    || is_misaligned(req_funct3, req_addr[1:0]);

    // Full-word stores go straight to memory in the accept cycle.
    assign sw_write = acc_access && req_is_store && !req_fault
                   && (req_funct3 == LSU_F3_W);

    lsu_align #(
        .XLEN        (XLEN)
    ) u_align (
        .funct3      (req_funct3),
        .addr_lo     (req_addr[1:0]),
        .rd_word     (mem_rd_data),
        .load_data   (load_data),
        .old_word    (mem_rd_data),
        .wr_data     (req_wr_data),
        .merged_word (merged_word)
    );

    always_comb begin
        state_d        = state_q;
        resp_rd_data_d = resp_rd_data_q;
        resp_fault_d   = resp_fault_q;
        rmw_addr_d     = rmw_addr_q;
        rmw_data_d     = rmw_data_q;
        case (state_q)
            IDLE: begin
                if (acc_access) begin
                    state_d        = RESP;
                    resp_fault_d   = req_fault;
                    resp_rd_data_d = RESET_RD_DATA;
                    if (!req_fault) begin
                        if (req_is_load) begin
                            resp_rd_data_d = load_data;
                        end else if (req_funct3 != LSU_F3_W) begin
                            state_d    = RMW_WR;
                            rmw_addr_d = addr_aligned;
                            rmw_data_d = merged_word;
                        end
                    end
                end
            end
            RMW_WR:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            resp_rd_data_q <= RESET_RD_DATA;
            resp_fault_q   <= 1'b0;
            rmw_addr_q     <= '0;
            rmw_data_q     <= '0;
        end else begin
            state_q        <= state_d;
            resp_rd_data_q <= resp_rd_data_d;
            resp_fault_q   <= resp_fault_d;
            rmw_addr_q     <= rmw_addr_d;
            rmw_data_q     <= rmw_data_d;
        end
    end

    assign resp_valid   = (state_q == RESP);
    assign resp_rd_data = resp_rd_data_q;
    assign resp_fault   = resp_fault_q;

    // Memory controls are decoded from state, and forced to zero while in
    // reset, so asserting rst_n low cancels an in-flight write at once.
    assign mem_wr_sel  = rst_n && ((state_q == RMW_WR) || sw_write);
    assign mem_addr    = !rst_n ? '0 :
                         (state_q == RMW_WR) ? rmw_addr_q : addr_aligned;
    assign mem_wr_data = !rst_n ? '0 :
                         (state_q == RMW_WR) ? rmw_data_q :
                         sw_write            ? req_wr_data : '0;

`ifdef LSU_PERF_CNT_EN
    logic [31:0] perf_loads_q,  perf_loads_d;
    logic [31:0] perf_stores_q, perf_stores_d;
    logic [31:0] perf_faults_q, perf_faults_d;

    // Counted on the transition into RESP; a sub-word store counts as it
    // leaves RMW_WR.
    always_comb begin
        perf_loads_d  = perf_loads_q;
        perf_stores_d = perf_stores_q;
        perf_faults_d = perf_faults_q;
        if (acc_access && req_fault)
            perf_faults_d = perf_faults_q + 32'd1;
        if (acc_access && !req_fault && req_is_load)
            perf_loads_d = perf_loads_q + 32'd1;
        if (sw_write || (state_q == RMW_WR))
            perf_stores_d = perf_stores_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_loads_q  <= '0;
            perf_stores_q <= '0;
            perf_faults_q <= '0;
        end else begin
            perf_loads_q  <= perf_loads_d;
            perf_stores_q <= perf_stores_d;
            perf_faults_q <= perf_faults_d;
        end
    end

    assign perf_loads  = perf_loads_q;
    assign perf_stores = perf_stores_q;
    assign perf_faults = perf_faults_q;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: self-checking bench for lsu_ctrl with a word memory model,
// a directed vector table, hand-written handshake/reset sequences and
// randomized requests checked against a byte-level reference model.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_is_load, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wr_data;
    logic        resp_valid, resp_fault, mem_wr_sel;
    logic [31:0] resp_rd_data, mem_addr, mem_wr_data, mem_rd_data;
`ifdef LSU_PERF_CNT_EN
    logic [31:0] perf_loads, perf_stores, perf_faults;
`endif

    always #5 clk = ~clk;

    lsu_ctrl #(.XLEN(32), .RESET_RD_DATA(32'h0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_load  (req_is_load),
        .req_is_store (req_is_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wr_data  (req_wr_data),
        .resp_valid   (resp_valid),
        .resp_rd_data (resp_rd_data),
        .resp_fault   (resp_fault),
        .mem_wr_sel   (mem_wr_sel),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_rd_data  (mem_rd_data)
`ifdef LSU_PERF_CNT_EN
        ,
        .perf_loads   (perf_loads),
        .perf_stores  (perf_stores),
        .perf_faults  (perf_faults)
`endif
    );

    // Memory model: 64 words, aliased on address bits [7:2].
    logic [31:0] tbmem     [64];
    logic [31:0] init_word [64];
    logic        mem_init;
    assign mem_rd_data = tbmem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) tbmem[i] <= init_word[i];
        end else if (mem_wr_sel) begin
            tbmem[mem_addr[7:2]] <= mem_wr_data;
        end
    end

    // Reference model state: flat byte memory plus class counters.
    logic [7:0] ref_mem [256];
    int ref_nl, ref_ns, ref_nf;
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    endfunction

    // Access semantics from the RV32I rules: size/sign from funct3,
    // natural alignment, little-endian bytes.
    task automatic ref_req(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rd, output logic flt, output int lat);
        int size;
        bit uns;
        int a;
        size = 1; uns = 0; flt = 0; rd = 32'h0; lat = 1;
        if (ld && st) flt = 1;
        else if (ld) begin
            case (f3)
                3'd0: size = 1;
                3'd1: size = 2;
                3'd2: size = 4;
                3'd4: begin size = 1; uns = 1; end
                3'd5: begin size = 2; uns = 1; end
                default: flt = 1;
            endcase
        end else begin
            case (f3)
                3'd0: size = 1;
                3'd1: size = 2;
                3'd2: size = 4;
                default: flt = 1;
            endcase
        end
        if (!flt && (int'(addr[1:0]) % size) != 0) flt = 1;
        if (flt) begin
            ref_nf++;
            return;
        end
        a = int'(addr[7:0]);
        if (ld) begin
            for (int b = 0; b < size; b++) rd = rd | (32'(ref_mem[a+b]) << (8*b));
            if (!uns && size < 4 && rd[8*size-1]) rd = rd | (32'hFFFF_FFFF << (8*size));
            ref_nl++;
        end else begin
            for (int b = 0; b < size; b++) ref_mem[a+b] = wdata[8*b +: 8];
            lat = (size == 4) ? 1 : 2;
            ref_ns++;
        end
    endtask

    // One isolated request; lat = negedges from accept to resp_valid (-1 on timeout).
    task automatic do_req(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic flt, output int lat);
        @(negedge clk);
        chk("ready_idle", {31'b0, req_ready}, 32'd1);
        req_is_load = ld; req_is_store = st; req_funct3 = f3;
        req_addr = addr; req_wr_data = wdata; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
        lat = -1;
        rd = 32'h0; flt = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = c; rd = resp_rd_data; flt = resp_fault;
                break;
            end
        end
        $display("txn ld=%0d st=%0d f3=%0d addr=%h wdata=%h -> rd=%h fault=%0d lat=%0d",
                 ld, st, f3, addr, wdata, rd, flt, lat);
    endtask

    typedef struct {
        logic        ld, st;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, exp_rd;
        logic        exp_flt;
        int          exp_lat;
        logic        chk_rd;
    } vec_t;

    function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rd, input logic exp_flt,
                                input int exp_lat, input logic chk_rd);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_rd = exp_rd; v.exp_flt = exp_flt; v.exp_lat = exp_lat; v.chk_rd = chk_rd;
        return v;
    endfunction

    vec_t        vt[$];
    vec_t        bb[4];
    logic [31:0] exp_q[$];
    logic [31:0] rd, ref_rd, saved;
    logic        flt, ref_flt;
    int          lat, ref_lat, idx, accs, rsps, extra;
    logic        acc_now, both_hi;
    logic [31:0] ra;

    initial begin
        rst_n = 1'b0; mem_init = 1'b1;
        req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
        req_funct3 = 3'd0; req_addr = 32'h44; req_wr_data = 32'h1234_5678;
        ref_nl = 0; ref_ns = 0; ref_nf = 0;
        for (int i = 0; i < 64; i++) begin
            init_word[i] = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4*i+b] = init_word[i][8*b +: 8];
        end

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_fault", {31'b0, resp_fault}, 32'd0);
        chk("rst_rd_data", resp_rd_data, 32'h0);
        chk("rst_mem_wr_sel", {31'b0, mem_wr_sel}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wr_data", mem_wr_data, 32'h0);
        rst_n = 1'b1; mem_init = 1'b0;

        // Directed vector table
        vt.push_back(mk(0, 1, LSU_F3_W,  32'h10, 32'hDEADBEEF, 32'h0, 0, 1, 0));
        vt.push_back(mk(1, 0, LSU_F3_W,  32'h10, 32'h0, 32'hDEADBEEF, 0, 1, 1));
        vt.push_back(mk(1, 0, LSU_F3_B,  32'h13, 32'h0, 32'hFFFFFFDE, 0, 1, 1));
        vt.push_back(mk(1, 0, LSU_F3_BU, 32'h13, 32'h0, 32'h000000DE, 0, 1, 1));
        vt.push_back(mk(1, 0, LSU_F3_HU, 32'h12, 32'h0, 32'h0000DEAD, 0, 1, 1));
        vt.push_back(mk(0, 1, LSU_F3_B,  32'h11, 32'h55, 32'h0, 0, 2, 0));
        vt.push_back(mk(1, 0, LSU_F3_W,  32'h10, 32'h0, 32'hDEAD55EF, 0, 1, 1));
        vt.push_back(mk(0, 1, LSU_F3_W,  32'h10, 32'hDEADBEEF, 32'h0, 0, 1, 0));
        vt.push_back(mk(0, 1, LSU_F3_H,  32'h12, 32'h1234, 32'h0, 0, 2, 0));
        vt.push_back(mk(1, 0, LSU_F3_W,  32'h10, 32'h0, 32'h1234BEEF, 0, 1, 1));
        vt.push_back(mk(1, 0, LSU_F3_H,  32'h12, 32'h0, 32'h00001234, 0, 1, 1));
        vt.push_back(mk(0, 1, LSU_F3_W,  32'h11, 32'hCAFEF00D, 32'h0, 1, 1, 1));
        vt.push_back(mk(1, 0, LSU_F3_H,  32'h13, 32'h0, 32'h0, 1, 1, 1));
        vt.push_back(mk(1, 0, 3'b011,    32'h10, 32'h0, 32'h0, 1, 1, 1));
        vt.push_back(mk(1, 1, LSU_F3_W,  32'h10, 32'h0, 32'h0, 1, 1, 1));
        vt.push_back(mk(0, 1, 3'b011,    32'h10, 32'h0, 32'h0, 1, 1, 1));
        vt.push_back(mk(1, 0, LSU_F3_W,  32'h10, 32'h0, 32'h1234BEEF, 0, 1, 1));
        for (int i = 0; i < vt.size(); i++) begin
            ref_req(vt[i].ld, vt[i].st, vt[i].f3, vt[i].addr, vt[i].wdata, ref_rd, ref_flt, ref_lat);
            do_req(vt[i].ld, vt[i].st, vt[i].f3, vt[i].addr, vt[i].wdata, rd, flt, lat);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].exp_lat));
            chk($sformatf("vec%0d_fault", i), {31'b0, flt}, {31'b0, vt[i].exp_flt});
            if (vt[i].chk_rd) chk($sformatf("vec%0d_rd", i), rd, vt[i].exp_rd);
        end

        // Ignored request: valid with neither load nor store
        @(negedge clk);
        req_valid = 1'b1; req_is_load = 1'b0; req_is_store = 1'b0; req_addr = 32'h20;
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid || !req_ready) extra++;
        end
        req_valid = 1'b0;
        chk("ignored_no_resp", 32'(extra), 32'd0);
        $display("txn ignored valid-without-op -> no response");

        // Back-to-back: req_valid held high across four requests
        bb[0] = mk(0, 1, LSU_F3_W, 32'h20, 32'hA5A51234, 0, 0, 0, 0);
        bb[1] = mk(0, 1, LSU_F3_B, 32'h21, 32'h7E, 0, 0, 0, 0);
        bb[2] = mk(1, 0, LSU_F3_W, 32'h20, 32'h0, 0, 0, 0, 0);
        bb[3] = mk(1, 0, LSU_F3_H, 32'h22, 32'h0, 0, 0, 0, 0);
        idx = 0; accs = 0; rsps = 0; both_hi = 1'b0;
        @(posedge clk);
        #1;
        req_is_load = bb[0].ld; req_is_store = bb[0].st; req_funct3 = bb[0].f3;
        req_addr = bb[0].addr; req_wr_data = bb[0].wdata; req_valid = 1'b1;
        for (int c = 0; c < 40 && rsps < 4; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                if (req_ready) both_hi = 1'b1;
                if (exp_q.size() > 0) begin
                    chk($sformatf("b2b%0d_rd", rsps), resp_rd_data, exp_q.pop_front());
                    chk($sformatf("b2b%0d_fault", rsps), {31'b0, resp_fault}, 32'd0);
                end
                $display("txn b2b resp %0d rd=%h", rsps, resp_rd_data);
                rsps++;
            end
            acc_now = req_valid && req_ready;
            if (acc_now) begin
                ref_req(bb[idx].ld, bb[idx].st, bb[idx].f3, bb[idx].addr, bb[idx].wdata,
                        ref_rd, ref_flt, ref_lat);
                exp_q.push_back(ref_rd);
                accs++;
            end
            @(posedge clk);
            #1;
            if (acc_now) begin
                idx++;
                if (idx < 4) begin
                    req_is_load = bb[idx].ld; req_is_store = bb[idx].st;
                    req_funct3 = bb[idx].f3; req_addr = bb[idx].addr;
                    req_wr_data = bb[idx].wdata;
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) extra++;
        end
        chk("b2b_accepts", 32'(accs), 32'd4);
        chk("b2b_resps", 32'(rsps), 32'd4);
        chk("b2b_no_extra_resp", 32'(extra), 32'd0);
        chk("b2b_ready_low_in_resp", {31'b0, both_hi}, 32'd0);

        // Randomized requests against the reference model
        for (int n = 0; n < 250; n++) begin
            logic ld, st;
            logic [2:0] f3;
            logic [31:0] addr, wdata;
            int r;
            r = $urandom_range(0, 19);
            ld = (r < 11) || (r == 19);
            st = (r >= 11);
            f3 = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = (f3[1:0] == 2'b10) ? 2'b00 :
                                                       (f3[1:0] == 2'b01) ? {addr[1], 1'b0} : addr[1:0];
            wdata = $urandom;
            ref_req(ld, st, f3, addr, wdata, ref_rd, ref_flt, ref_lat);
            do_req(ld, st, f3, addr, wdata, rd, flt, lat);
            chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'(ref_lat));
            chk($sformatf("rnd%0d_fault", n), {31'b0, flt}, {31'b0, ref_flt});
            if (ld || ref_flt) chk($sformatf("rnd%0d_rd", n), rd, ref_rd);
        end
        @(negedge clk);
        for (int w = 0; w < 64; w++) chk($sformatf("mem_word%0d", w), tbmem[w], ref_word(w));

`ifdef LSU_PERF_CNT_EN
        chk("perf_loads", perf_loads, 32'(ref_nl));
        chk("perf_stores", perf_stores, 32'(ref_ns));
        chk("perf_faults", perf_faults, 32'(ref_nf));
`endif

        // Reset asserted during RMW_WR cancels the write
        saved = ref_word(12);
        @(negedge clk);
        req_is_load = 1'b0; req_is_store = 1'b1; req_funct3 = LSU_F3_B;
        req_addr = 32'h31; req_wr_data = ~saved; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_is_store = 1'b0;
        chk("rmw_wr_sel_high", {31'b0, mem_wr_sel}, 32'd1);
        chk("rmw_wr_addr", mem_addr, 32'h30);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmw_rst_wr_sel", {31'b0, mem_wr_sel}, 32'd0);
        chk("rmw_rst_mem_addr", mem_addr, 32'h0);
        chk("rmw_rst_mem_wr_data", mem_wr_data, 32'h0);
        chk("rmw_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rmw_rst_resp_fault", {31'b0, resp_fault}, 32'd0);
        chk("rmw_rst_rd_data", resp_rd_data, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ref_nl = 0; ref_ns = 0; ref_nf = 0;
        chk("rmw_rst_no_write", tbmem[12], saved);
        $display("txn reset during RMW_WR, word 0x30 = %h", tbmem[12]);
        ref_req(1, 0, LSU_F3_W, 32'h30, 32'h0, ref_rd, ref_flt, ref_lat);
        do_req(1, 0, LSU_F3_W, 32'h30, 32'h0, rd, flt, lat);
        chk("post_rst_lw", rd, saved);
        chk("post_rst_lat", 32'(lat), 32'd1);
`ifdef LSU_PERF_CNT_EN
        chk("post_rst_perf_loads", perf_loads, 32'(ref_nl));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
